uart_tx_gen2: RTL and testbench

UART_TX_GEN2 -- requirements
Module: uart_tx_gen2

---
 rtl/uart_tx_gen2.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_gen2.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_gen2.sv
// Purpose: UART transmitter, 5..9 data bits, optional even/odd parity, 1 or 2 stop bits, runtime prescale.
// Latency: start bit drives S_data right after the accepting edge; each bit lasts max(prescale,1) clk cycles.
// Backpressure: ready/data_valid handshake; ready only in IDLE, or while the one-word holding register
//   is empty when UART_TX_HOLD_BUF_EN is defined.
module uart_tx_gen2 #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    output logic                  ready,
    input  logic                  par_en,
    input  logic                  par_type,
    input  logic                  stop2,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  S_data,
    output logic                  BUSY
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Everything a frame needs, captured once at acceptance. data is shifted
    // out LSB first, so parity is computed up front from the unshifted word.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  par_en;
        logic                  parity;
        logic                  stop2;
        logic [PRESCALE_W-1:0] presc;
    } frame_t;

    state_t              state_q, state_d;
    frame_t              frm_q, frm_d;
    frame_t              in_word;
    frame_t              next_word;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic                stop_idx_q, stop_idx_d;
    logic                rdy_q;
    logic                accept;
    logic                bit_end;
    logic                last_stop;
    logic                next_vld;

`ifdef UART_TX_HOLD_BUF_EN
    frame_t              hold_q, hold_d;
    logic                hold_vld_q, hold_vld_d;
`endif

    // Capture the offered word and config; prescale 0 is treated as 1 cycle per bit.
    always_comb begin
        in_word.data     = p_data;
        in_word.par_en   = par_en;
        in_word.parity   = (^p_data) ^ par_type;
        in_word.stop2    = stop2;
        in_word.presc    = (prescale == '0) ? PRESCALE_W'(1) : prescale;
    end

    assign accept    = data_valid & ready;
    assign bit_end   = (cnt_q == (frm_q.presc - PRESCALE_W'(1)));
    assign last_stop = (state_q == STOP) && bit_end && (!frm_q.stop2 || stop_idx_q);

`ifdef UART_TX_HOLD_BUF_EN
    // A parked word has priority at frame end; otherwise a same-edge accept chains directly.
    assign next_vld  = hold_vld_q | accept;
    assign next_word = hold_vld_q ? hold_q : in_word;
    assign ready     = rdy_q & ((state_q == IDLE) | ~hold_vld_q);
`else
    // Without the holding register ready is low in STOP, so no chaining occurs here.
    assign next_vld  = accept;
    assign next_word = in_word;
    assign ready     = rdy_q & (state_q == IDLE);
`endif

    assign BUSY = (state_q != IDLE);

    // Serial line value follows the current state; idle and stop are high.
    always_comb begin
        S_data = 1'b1;
        case (state_q)
            START:   S_data = 1'b0;
            DATA:    S_data = frm_q.data[0];
            PARITY:  S_data = frm_q.parity;
            default: S_data = 1'b1;
        endcase
    end

    // Next-state, bit-period counter and frame shift logic.
    always_comb begin
        state_d    = state_q;
        frm_d      = frm_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : (cnt_q + PRESCALE_W'(1));
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    frm_d   = in_word;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    frm_d.data = frm_q.data >> 1;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d    = frm_q.par_en ? PARITY : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!last_stop) begin
                        stop_idx_d = 1'b1;
                    end else if (next_vld) begin
                        state_d = START;
                        frm_d   = next_word;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_TX_HOLD_BUF_EN
    // Holding register: park a mid-frame word, release it when the last stop bit ends.
    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (last_stop && hold_vld_q) begin
            hold_vld_d = 1'b0;
        end else if (accept && (state_q != IDLE) && !last_stop) begin
            hold_vld_d = 1'b1;
            hold_d     = in_word;
        end
    end

    // Holding register storage, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end
`endif

    // State, counters and frame register; ready is held off until the first edge out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            frm_q      <= '0;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            frm_q      <= frm_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            rdy_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Purpose: directed self-checking bench for uart_tx_gen2 (8-bit and 5-bit instances).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: words offered only once ready is seen high, bounded by a cycle budget.
module tb_uart_tx_gen2;

    logic       clk = 1'b0;
    logic       rst;
    logic       par_en, par_type, stop2;

    logic [7:0] p_data8;
    logic       valid8, ready8, s8, busy8;
    logic [7:0] presc8;

    logic [4:0] p_data5;
    logic       valid5, ready5, s5, busy5;
    logic [7:0] presc5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_gen2 #(.DATA_WIDTH(8), .PRESCALE_W(8)) dut8 (
        .clk(clk), .rst(rst), .p_data(p_data8), .data_valid(valid8), .ready(ready8),
        .par_en(par_en), .par_type(par_type), .stop2(stop2), .prescale(presc8),
        .S_data(s8), .BUSY(busy8)
    );

    uart_tx_gen2 #(.DATA_WIDTH(5), .PRESCALE_W(8)) dut5 (
        .clk(clk), .rst(rst), .p_data(p_data5), .data_valid(valid5), .ready(ready5),
        .par_en(par_en), .par_type(par_type), .stop2(stop2), .prescale(presc5),
        .S_data(s5), .BUSY(busy5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for ready, then offer one word for exactly one edge.
    task automatic send(input bit use5, input logic [7:0] d);
        int t = 0;
        while (!(use5 ? ready5 : ready8) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk(use5 ? "ready5_wait" : "ready8_wait", use5 ? ready5 : ready8, 1);
        if (use5) begin
            p_data5 = d[4:0]; valid5 = 1'b1;
        end else begin
            p_data8 = d; valid8 = 1'b1;
        end
        @(posedge clk); #1;
        valid5 = 1'b0;
        valid8 = 1'b0;
    endtask

    // Called 1 unit after the accepting edge; bits[i] is the i-th bit on the line.
    task automatic check_frame(input string tag, input logic [11:0] bits, input int nbits,
                               input int p, input bit use5, input bit end_idle);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < p; c++) begin
                chk($sformatf("%s_bit%0d_c%0d", tag, i, c), use5 ? s5 : s8, bits[i]);
                chk($sformatf("%s_busy%0d_c%0d", tag, i, c), use5 ? busy5 : busy8, 1);
                @(posedge clk); #1;
            end
        end
        if (end_idle) begin
            chk({tag, "_end_busy"}, use5 ? busy5 : busy8, 0);
            chk({tag, "_end_line"}, use5 ? s5 : s8, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        par_en = 1'b0; par_type = 1'b0; stop2 = 1'b0;
        p_data8 = '0; valid8 = 1'b0; presc8 = 8'd4;
        p_data5 = '0; valid5 = 1'b0; presc5 = 8'd3;

        // Reset state
        #3;
        chk("rst_line8", s8, 1);
        chk("rst_busy8", busy8, 0);
        chk("rst_ready8", ready8, 0);
        chk("rst_ready5", ready5, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_before_edge", ready8, 0);
        @(posedge clk); #1;
        chk("ready_after_edge", ready8, 1);
        chk("idle_line", s8, 1);

        // 8N1, A5, prescale 4; inputs changed mid-frame must not matter
        send(0, 8'hA5);
        p_data8 = 8'hFF; par_en = 1'b1; stop2 = 1'b1; presc8 = 8'd1;
        check_frame("a5", 12'b00_1101001010, 10, 4, 0, 1);
        par_en = 1'b0; stop2 = 1'b0; presc8 = 8'd4;

        // 8E1 and 8O1 with 07
        par_en = 1'b1; par_type = 1'b0;
        send(0, 8'h07);
        check_frame("even07", 12'b0_11000001110, 11, 4, 0, 1);
        par_type = 1'b1;
        send(0, 8'h07);
        check_frame("odd07", 12'b0_10000001110, 11, 4, 0, 1);
        par_en = 1'b0; par_type = 1'b0;

        // 8N2 with prescale 0 -> one cycle per bit, 11 cycles
        stop2 = 1'b1; presc8 = 8'd0;
        send(0, 8'h3C);
        check_frame("n2_3c", 12'b0_11001111000, 11, 1, 0, 1);
        stop2 = 1'b0; presc8 = 8'd4;

`ifdef UART_TX_HOLD_BUF_EN
        // Second word parked during DATA, chained with no idle cycle
        send(0, 8'h11);
        fork
            begin
                check_frame("hold11", 12'b00_1000100010, 10, 4, 0, 0);
                check_frame("hold22", 12'b00_1001000100, 10, 4, 0, 1);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("hold_ready_mid", ready8, 1);
                p_data8 = 8'h22; valid8 = 1'b1;
                @(posedge clk); #1;
                valid8 = 1'b0;
                chk("hold_ready_full", ready8, 0);
            end
        join
`else
        // Word offered mid-frame while ready is low must be dropped
        send(0, 8'h11);
        fork
            check_frame("nohold11", 12'b00_1000100010, 10, 4, 0, 1);
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("nohold_ready_mid", ready8, 0);
                p_data8 = 8'h22; valid8 = 1'b1;
                @(posedge clk); #1;
                valid8 = 1'b0;
            end
        join
        repeat (4) begin
            @(posedge clk); #1;
            chk("nohold_stays_idle", busy8, 0);
            chk("nohold_line_high", s8, 1);
        end
`endif

        // Asynchronous reset during data bit 3 (line would be 0 there)
        send(0, 8'hA5);
        repeat (17) @(posedge clk);
        #2;
        chk("pre_rst_line", s8, 0);
        rst = 1'b0;
        #1;
        chk("midrst_line", s8, 1);
        chk("midrst_busy", busy8, 0);
        chk("midrst_ready", ready8, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_ready_before_edge", ready8, 0);
        @(posedge clk); #1;
        chk("rel_ready_after_edge", ready8, 1);
        chk("rel_busy", busy8, 0);
        send(0, 8'h11);
        check_frame("after_rst11", 12'b00_1000100010, 10, 4, 0, 1);

        // 5-bit instance: prescale changed mid-frame keeps old timing
        presc5 = 8'd3;
        send(1, 8'h16);
        presc5 = 8'd7;
        check_frame("w5_16", 12'b00000_1101100, 7, 3, 1, 1);
        send(1, 8'h09);
        check_frame("w5_09", 12'b00000_1010010, 7, 7, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
